// File: rtl/axi_lite_slave_regs.sv
// ============================================================================
// Module  : axi_lite_slave_regs
// Brief   : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int         c_idx_w  = $clog2(NUM_REGS);
  localparam int         c_strb_w = DATA_WIDTH / 8;
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  logic                  r_init_done;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [c_strb_w-1:0]   w_wr_strb;
  logic                  w_wr_in_range;
  logic [c_idx_w-1:0]    w_wr_idx;
  logic                  w_rd_in_range;
  logic [c_idx_w-1:0]    w_rd_idx;
  logic                  w_unused_addr_lsbs;

  // Readies come only from registered state; r_init_done holds them low in reset.
  assign AWREADY = r_init_done & ~r_aw_held & ~r_bvalid;
  assign WREADY  = r_init_done & ~r_w_held  & ~r_bvalid;
  assign ARREADY = r_init_done & ~r_rvalid;

  assign w_aw_hs = AWVALID & AWREADY;
  assign w_w_hs  = WVALID  & WREADY;
  assign w_ar_hs = ARVALID & ARREADY;

  // A payload counts as present whether latched earlier or arriving this edge.
  assign w_wr_addr = r_aw_held ? r_awaddr : AWADDR;
  assign w_wr_data = r_w_held  ? r_wdata  : WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb  : WSTRB;
  assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

  assign w_wr_in_range = (w_wr_addr >> (c_idx_w + 2)) == '0;
  assign w_wr_idx      = w_wr_addr[c_idx_w+1:2];
  assign w_rd_in_range = (ARADDR >> (c_idx_w + 2)) == '0;
  assign w_rd_idx      = ARADDR[c_idx_w+1:2];

  assign w_unused_addr_lsbs = ^{w_wr_addr[1:0], ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_okay;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_in_range ? c_okay : c_slverr;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
      if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_wr_in_range) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (w_wr_strb[b]) begin
          r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Sampling r_regs before this edge's commit gives read-before-write ordering.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_okay;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
      r_rresp  <= w_rd_in_range ? c_okay : c_slverr;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign BVALID = r_bvalid;
  assign BRESP  = r_bresp;
  assign RVALID = r_rvalid;
  assign RDATA  = r_rdata;
  assign RRESP  = r_rresp;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
// ============================================================================
// Module  : tb_axi_lite_slave_regs
// Brief   : Randomized self-checking bench for axi_lite_slave_regs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_slave_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic           ACLK;
  logic           ARESETn;
  logic [AW-1:0]  AWADDR;
  logic           AWVALID;
  logic           AWREADY;
  logic [DW-1:0]  WDATA;
  logic [DW/8-1:0] WSTRB;
  logic           WVALID;
  logic           WREADY;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [AW-1:0]  ARADDR;
  logic           ARVALID;
  logic           ARREADY;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RVALID;
  logic           RREADY;
  logic [NR*DW-1:0] regs_o;

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [NR];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a < NR * 4;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_range(a) ? model[int'(a / 4)] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_regs_o();
    for (int i = 0; i < NR; i++) check("regs_o", regs_o[i*DW +: DW], model[i]);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (in_range(a)) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[int'(a / 4)] = (model[int'(a / 4)] & ~mask) | (d & mask);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_wait);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && cyc >= aw_dly;
      WVALID  = !w_done && cyc >= w_dly;
      @(negedge ACLK);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      tick();
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      cyc++;
      if (!(aw_done && w_done)) begin
        check("bvalid_early", {31'b0, BVALID}, 0);
        if (w_done)  check("wready_held", {31'b0, WREADY}, 0);
        if (aw_done) check("awready_held", {31'b0, AWREADY}, 0);
      end
    end
    AWVALID = 0; WVALID = 0;
    check("wr_handshake", {31'b0, aw_done && w_done}, 1);
    if (!(aw_done && w_done)) return;
    model_write(a, d, s);
    check("bvalid", {31'b0, BVALID}, 1);
    check("bresp", {30'b0, BRESP}, {30'b0, exp_resp(a)});
    check_regs_o();
    for (int k = 0; k < b_wait; k++) begin
      tick();
      check("bvalid_hold", {31'b0, BVALID}, 1);
      check("bresp_hold", {30'b0, BRESP}, {30'b0, exp_resp(a)});
      check("aw_w_ready_stall", {30'b0, AWREADY, WREADY}, 0);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    check("bvalid_clear", {31'b0, BVALID}, 0);
    check("aw_w_ready_back", {30'b0, AWREADY, WREADY}, 3);
  endtask

  task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_wait);
    bit fire;
    int cyc;
    logic [31:0] ed;
    logic [1:0] er;
    fire = 0; cyc = 0;
    ARADDR = a;
    ed = exp_rdata(a);
    er = exp_resp(a);
    while (!fire && cyc < 40) begin
      ARVALID = cyc >= ar_dly;
      @(negedge ACLK);
      fire = ARVALID && ARREADY;
      tick();
      cyc++;
    end
    ARVALID = 0;
    check("rd_handshake", {31'b0, fire}, 1);
    if (!fire) return;
    check("rvalid", {31'b0, RVALID}, 1);
    check("rdata", RDATA, ed);
    check("rresp", {30'b0, RRESP}, {30'b0, er});
    for (int k = 0; k < r_wait; k++) begin
      tick();
      check("rvalid_hold", {31'b0, RVALID}, 1);
      check("rdata_hold", RDATA, ed);
      check("arready_stall", {31'b0, ARREADY}, 0);
    end
    RREADY = 1;
    tick();
    RREADY = 0;
    check("rvalid_clear", {31'b0, RVALID}, 0);
    check("arready_back", {31'b0, ARREADY}, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, old;
    ARESETn = 0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = 0;
    #23;
    check("rst_readys", {29'b0, AWREADY, WREADY, ARREADY}, 0);
    check("rst_valids", {30'b0, BVALID, RVALID}, 0);
    check("rst_rdata", RDATA, 0);
    check_regs_o();
    @(negedge ACLK);
    ARESETn = 1;
    tick();
    check("post_rst_readys", {29'b0, AWREADY, WREADY, ARREADY}, 3'b111);

    // Same-cycle AW+W, then read back
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg2", regs_o[2*DW +: DW], 32'hDEADBEEF);
    axi_read(32'h08, 0, 0);

    // W three cycles ahead of AW, partial strobe
    axi_write(32'h04, 32'h11223344, 4'b0101, 3, 0, 0);
    check("reg1", regs_o[1*DW +: DW], 32'h00220044);

    // Out-of-range write then read
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, 0);

    // Backpressure on both response channels
    axi_write(32'h0C, 32'h5A5AA5A5, 4'hF, 0, 1, 5);
    axi_read(32'h0C, 0, 5);

    // Write commit and read to the same register on one edge
    old = model[2];
    AWADDR = 32'h08; WDATA = 32'h0BADF00D; WSTRB = 4'hF; ARADDR = 32'h08;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(negedge ACLK);
    check("concurrent_readys", {29'b0, AWREADY, WREADY, ARREADY}, 3'b111);
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    model_write(32'h08, 32'h0BADF00D, 4'hF);
    check("concurrent_rdata", RDATA, old);
    check("concurrent_bvalid", {30'b0, BVALID, RVALID}, 3);
    check_regs_o();
    BREADY = 1; RREADY = 1;
    tick();
    BREADY = 0; RREADY = 0;

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h40 + ($urandom & 32'h3F);
        1:       a = $urandom;
        default: a = $urandom & 32'h3F;
      endcase
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset with an AW held and a read response pending
    AWADDR = 32'h10; AWVALID = 1; ARADDR = 32'h08; ARVALID = 1;
    tick();
    AWVALID = 0; ARVALID = 0;
    check("pre_rst_rvalid", {31'b0, RVALID}, 1);
    #2;
    ARESETn = 0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 0;
    check("midrst_readys", {29'b0, AWREADY, WREADY, ARREADY}, 0);
    check("midrst_valids", {30'b0, BVALID, RVALID}, 0);
    check("midrst_resps", {28'b0, BRESP, RRESP}, 0);
    check("midrst_rdata", RDATA, 0);
    check_regs_o();
    @(negedge ACLK);
    ARESETn = 1;
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
    tick();
    check("midrst_readys_back", {29'b0, AWREADY, WREADY, ARREADY}, 3'b111);
    tick();
    WVALID = 0;
    for (int k = 0; k < 4; k++) begin
      check("no_stale_bvalid", {31'b0, BVALID}, 0);
      tick();
    end
    for (int i = 0; i < NR; i++) axi_read(32'(i * 4), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported, so WSTRB is 4 bits.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; power of two, 2..256.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, exactly as decided:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have the write-channel ports:
- AWADDR  in  ADDR_WIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte enables
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
REQ-006 SHALL have the read-channel and observation ports:
- ARADDR  in  ADDR_WIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-007 SHALL decode word index = addr[log2(NUM_REGS)+1:2].
- addr[1:0] is ignored.
- An address is in range iff addr < NUM_REGS*4.
REQ-008 Write path SHALL hold flags aw_held and w_held, which latch AWADDR and WDATA/WSTRB independently.
- AW and W may be accepted in either order or in the same cycle.
REQ-009 SHALL drive AWREADY = !aw_held && !BVALID and WREADY = !w_held && !BVALID.
- Each is deasserted in the cycle after its handshake.
REQ-010 At the first edge where both payloads are held (latched or handshaking that edge) and BVALID=0, SHALL update the addressed register and set BVALID=1; both flags then clear.
- Register update: byte b is written iff WSTRB[b]=1.
- Latency: AW+W handshake at the same edge N gives BVALID=1 after edge N.
REQ-011 SHALL set BRESP=2'b00 (OKAY) for in-range writes and 2'b10 (SLVERR) for out-of-range writes; an out-of-range write modifies no register.
REQ-012 SHALL hold BVALID and BRESP stable until BREADY=1 at a rising edge, then clear BVALID.
- AWREADY and WREADY reassert in the next cycle.
- At most one write is outstanding.
REQ-013 Read path SHALL drive ARREADY = !RVALID.
- On an AR handshake at edge N, RVALID=1 after edge N with registered RDATA/RRESP (one-cycle latency).
REQ-014 In-range reads SHALL return RDATA = register value and RRESP=2'b00; out-of-range reads return RDATA=0 and RRESP=2'b10.
REQ-015 SHALL hold RVALID, RDATA and RRESP stable until RREADY=1 at a rising edge.
- RVALID then clears and ARREADY reasserts in the next cycle.
- At most one read is outstanding.
REQ-016 The read and write paths SHALL operate concurrently and independently.
- If a write commit and an AR handshake to the same register share an edge, RDATA returns the pre-write value.
REQ-017 Outputs SHALL never depend combinationally on VALID or READY inputs: READY signals derive only from registered state, and there are no combinational loops.
REQ-018 regs_o SHALL reflect register contents registered, updating after the commit edge.

Reset
REQ-019 While ARESETn=0, SHALL asynchronously force:
- all registers = 0
- aw_held = w_held = 0
- BVALID = RVALID = 0
- BRESP = RRESP = 2'b00, RDATA = 0
REQ-020 While ARESETn=0, SHALL drive AWREADY, WREADY and ARREADY to 0.
- Reset mid-transaction discards any held payload and pending response without performing a write.
REQ-021 After ARESETn rises, AWREADY, WREADY and ARREADY SHALL be 1 from the first rising edge onward.

Verification
REQ-022 Write with AW+W in the same cycle:
- Stimulus: addr 0x08, data 0xDEADBEEF, WSTRB 4'hF, BREADY=1.
- Required: BVALID one cycle later with BRESP 00; reg2 = 0xDEADBEEF; a read of 0x08 returns 0xDEADBEEF with RRESP 00.
REQ-023 W before AW:
- Stimulus: WDATA 0x11223344 with WSTRB 4'b0101 to addr 0x04 (reg1=0), then AWVALID three cycles later.
- Required: WREADY low while W is held; reg1 = 0x00220044; a single BVALID.
REQ-024 Out-of-range access:
- Stimulus: write 0x40 (NUM_REGS=16), then read 0x40.
- Required: BRESP 10 with no register changed; RDATA 0 with RRESP 10.
REQ-025 Backpressure:
- Stimulus: BREADY=0 and RREADY=0 held for 5 cycles.
- Required: BVALID/BRESP and RVALID/RDATA stay stable; AWREADY, WREADY and ARREADY stay low; a second AW is not accepted until B completes.
REQ-026 Reset mid-operation:
- Stimulus: ARESETn=0 with AW held and an R response pending.
- Required: all outputs 0 immediately; after release, all registers read 0 and no BVALID appears.
